// File: rtl/elevator_interval_timer.sv
// elevator_interval_timer: prescaled up/down interval timer with one-shot/periodic modes, pause and clear
module elevator_interval_timer #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             direction,
    input  logic             mode,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] period,
    output logic             busy,
    output logic             done,
    output logic             expired
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    localparam logic [15:0] PRE_MAX = 16'(DIV - 1);
    state_t           r_state;
    logic [15:0]      r_pre;
    logic             r_dir;
    logic             r_mode;
    logic [WIDTH-1:0] r_term;
    logic [WIDTH-1:0] r_period;
    logic             r_busy;
    logic             r_done;
    logic             r_expired;
    logic             w_tick;
    logic [WIDTH-1:0] w_end;
    logic [WIDTH-1:0] w_reload;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_start_val;
    // Next count value: a periodic run sitting on its end value reloads instead of stepping
    always_comb begin
        w_tick      = r_pre == PRE_MAX;
        w_end       = r_dir ? r_term : '0;
        w_reload    = r_dir ? '0 : r_term;
        w_step      = (r_period == w_end) ? w_reload
                    : (r_dir ? r_period + WIDTH'(1) : r_period - WIDTH'(1));
        w_start_val = direction ? '0 : load_val;
    end
    // Control FSM with clear > start > stop priority; all outputs registered here
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_pre     <= '0;
            r_dir     <= 1'b0;
            r_mode    <= 1'b0;
            r_term    <= '0;
            r_period  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (clear) begin
                r_state   <= IDLE;
                r_pre     <= '0;
                r_period  <= '0;
                r_busy    <= 1'b0;
                r_expired <= 1'b0;
            end else if (start && r_state == PAUSE) begin
                r_state   <= RUN;
                r_busy    <= 1'b1;
                r_expired <= 1'b0;
            end else if (start) begin
                r_dir  <= direction;
                r_mode <= mode;
                r_term <= load_val;
                r_pre  <= '0;
                if (load_val == '0) begin
                    r_state   <= DONE;
                    r_period  <= '0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_expired <= 1'b1;
                end else begin
                    r_state   <= RUN;
                    r_period  <= w_start_val;
                    r_busy    <= 1'b1;
                    r_expired <= 1'b0;
                end
            end else if (stop && r_state == RUN) begin
                r_state <= PAUSE;
            end else if (r_state == RUN) begin
                r_pre <= w_tick ? '0 : r_pre + 16'd1;
                if (w_tick) begin
                    r_period <= w_step;
                    if (w_step == w_end) begin
                        r_done    <= 1'b1;
                        r_expired <= 1'b1;
                        if (!r_mode) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
            end
        end
    end
    assign period  = r_period;
    assign busy    = r_busy;
    assign done    = r_done;
    assign expired = r_expired;
endmodule

// File: tb/tb_elevator_interval_timer.sv
// tb_elevator_interval_timer: directed scoreboard bench for DIV=1 and DIV=3 instances
module tb_elevator_interval_timer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       direction = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] p1, p3;
    logic       b1, d1, e1, b3, d3, e3;
    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    string      tag_q[$];
    int         t2p[15] = '{2, 2, 1, 1, 1, 0, 0, 0, 2, 2, 2, 1, 1, 1, 0};

    elevator_interval_timer #(.WIDTH(4), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .direction(direction), .mode(mode), .load_val(load_val),
        .period(p1), .busy(b1), .done(d1), .expired(e1)
    );
    elevator_interval_timer #(.WIDTH(4), .DIV(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .direction(direction), .mode(mode), .load_val(load_val),
        .period(p3), .busy(b3), .done(d3), .expired(e3)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input bit sel, input int p, input bit b, input bit d, input bit e);
        exp_q.push_back({sel, 4'(p), b, d, e});
        tag_q.push_back(tag);
    endtask

    task automatic pop_check();
        logic [7:0] ex;
        logic [6:0] obs;
        string      tag;
        ex  = exp_q.pop_front();
        tag = tag_q.pop_front();
        obs = ex[7] ? {p3, b3, d3, e3} : {p1, b1, d1, e1};
        total++;
        assert (obs === ex[6:0]) else begin
            bad++;
            $error("FAIL %s: observed p=%0d b=%0b d=%0b e=%0b expected p=%0d b=%0b d=%0b e=%0b",
                   tag, obs[6:3], obs[2], obs[1], obs[0], ex[6:3], ex[2], ex[1], ex[0]);
        end
    endtask

    task automatic cyc(input string tag, input bit sel, input int p, input bit b, input bit d, input bit e);
        push(tag, sel, p, b, d, e);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic now(input string tag, input bit sel, input int p, input bit b, input bit d, input bit e);
        push(tag, sel, p, b, d, e);
        pop_check();
    endtask

    initial begin
        #2;
        now("reset1", 0, 0, 0, 0, 0);
        now("reset3", 1, 0, 0, 0, 0);
        #1 rst = 1'b1;
        cyc("idle_after_reset", 0, 0, 0, 0, 0);
        // 1: up one-shot to 5
        start = 1; direction = 1; mode = 0; load_val = 4'd5;
        cyc("t1_start", 0, 0, 1, 0, 0);
        start = 0;
        for (int i = 1; i <= 4; i++) cyc($sformatf("t1_up%0d", i), 0, i, 1, 0, 0);
        cyc("t1_end", 0, 5, 0, 1, 1);
        cyc("t1_hold_a", 0, 5, 0, 0, 1);
        cyc("t1_hold_b", 0, 5, 0, 0, 1);
        // 2: DIV=3 down periodic from 2
        clear = 1;
        cyc("t2_clear", 1, 0, 0, 0, 0);
        clear = 0; start = 1; direction = 0; mode = 1; load_val = 4'd2;
        cyc("t2_start", 1, 2, 1, 0, 0);
        start = 0;
        for (int i = 0; i < 15; i++)
            cyc($sformatf("t2_c%0d", i), 1, t2p[i], 1, (i == 5 || i == 14), (i >= 5));
        // 3: pause and resume, late input changes ignored
        start = 1; direction = 1; mode = 0; load_val = 4'd9;
        cyc("t3_start", 0, 0, 1, 0, 0);
        start = 0;
        for (int i = 1; i <= 4; i++) cyc($sformatf("t3_up%0d", i), 0, i, 1, 0, 0);
        stop = 1;
        cyc("t3_stop", 0, 4, 1, 0, 0);
        stop = 0; direction = 0; load_val = 4'd2;
        for (int i = 0; i < 5; i++) cyc($sformatf("t3_pause%0d", i), 0, 4, 1, 0, 0);
        start = 1;
        cyc("t3_resume", 0, 4, 1, 0, 0);
        start = 0;
        for (int i = 5; i <= 8; i++) cyc($sformatf("t3_up%0d", i), 0, i, 1, 0, 0);
        cyc("t3_end", 0, 9, 0, 1, 1);
        cyc("t3_hold", 0, 9, 0, 0, 1);
        // 4: zero terminal in both modes
        start = 1; direction = 1; mode = 0; load_val = 4'd0;
        cyc("t4_zero_os", 0, 0, 0, 1, 1);
        start = 0;
        cyc("t4_zero_os_after", 0, 0, 0, 0, 1);
        start = 1; mode = 1;
        cyc("t4_zero_per", 0, 0, 0, 1, 1);
        start = 0;
        cyc("t4_zero_per_a", 0, 0, 0, 0, 1);
        cyc("t4_zero_per_b", 0, 0, 0, 0, 1);
        // 5: clear beats start and stop; start beats stop
        start = 1; direction = 1; mode = 1; load_val = 4'd2;
        cyc("t5_start", 0, 0, 1, 0, 0);
        start = 0;
        cyc("t5_p1", 0, 1, 1, 0, 0);
        cyc("t5_p2", 0, 2, 1, 1, 1);
        cyc("t5_reload", 0, 0, 1, 0, 1);
        cyc("t5_p1b", 0, 1, 1, 0, 1);
        clear = 1; start = 1; stop = 1;
        cyc("t5_all", 0, 0, 0, 0, 0);
        clear = 0; start = 0; stop = 0;
        cyc("t5_idle", 0, 0, 0, 0, 0);
        start = 1; mode = 0; load_val = 4'd9;
        cyc("t5_start2", 0, 0, 1, 0, 0);
        start = 0;
        for (int i = 1; i <= 3; i++) cyc($sformatf("t5_up%0d", i), 0, i, 1, 0, 0);
        start = 1; stop = 1;
        cyc("t5_restart", 0, 0, 1, 0, 0);
        start = 0; stop = 0;
        cyc("t5_after", 0, 1, 1, 0, 0);
        // 6: asynchronous reset mid-count
        start = 1; mode = 1; load_val = 4'd6;
        cyc("t6_start", 0, 0, 1, 0, 0);
        start = 0;
        for (int i = 1; i <= 5; i++) cyc($sformatf("t6_up%0d", i), 0, i, 1, 0, 0);
        cyc("t6_end", 0, 6, 1, 1, 1);
        rst = 0;
        #1;
        now("t6_async1", 0, 0, 0, 0, 0);
        now("t6_async3", 1, 0, 0, 0, 0);
        #1 rst = 1;
        cyc("t6_idle_a", 0, 0, 0, 0, 0);
        cyc("t6_idle_b", 0, 0, 0, 0, 0);
        start = 1; load_val = 4'd1; mode = 0;
        cyc("t6_start2", 0, 0, 1, 0, 0);
        start = 0;
        cyc("t6_end2", 0, 1, 0, 1, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/elevator_interval_timer.md
Name: elevator_interval_timer

Overview:
Parametrised successor to the 4-bit up/down floor-travel/door timer. It loads a programmable terminal count, counts up or down at a prescaled tick rate, and flags expiry. It supports one-shot and periodic modes, pause/resume and synchronous clear. The elevator controller FSM uses it for door-open dwell, inter-floor travel time and periodic status refresh.

Parameters:
WIDTH, 4, bit width of count, terminal value and period output (legal 2..16)
DIV, 1, clock cycles per count tick (legal 1..65535); DIV=1 means one tick every cycle

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  start/restart/resume request, sampled each cycle
stop  input  1  pause request, sampled each cycle
clear  input  1  synchronous abort to IDLE
direction  input  1  1 = count up, 0 = count down; latched on start from IDLE/DONE or restart
mode  input  1  0 = one-shot, 1 = periodic; latched with direction
load_val  input  WIDTH  terminal value; latched on start from IDLE/DONE or restart
period  output  WIDTH  current count (registered)
busy  output  1  high in RUN and PAUSE
done  output  1  one-cycle pulse, registered together with the count reaching its end value
expired  output  1  sticky; set with every done pulse, cleared by start or clear

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, period=0, busy=0, done=0, expired=0, prescaler=0, latched direction/mode/terminal=0.
- States: IDLE, RUN, PAUSE, DONE.
- Control priority when inputs coincide: clear > start > stop.
- Internal prescaler:
  - Counts 0..DIV-1 only in RUN.
  - tick = (prescaler==DIV-1). The prescaler wraps to 0 on tick.
  - Prescaler holds in PAUSE. It is zeroed on start from IDLE/DONE, on restart, and on clear.
- start in IDLE, DONE or RUN (restart):
  - Latch load_val, direction and mode.
  - Set period = 0 (up) or load_val (down). Set expired=0 and prescaler=0.
  - Next state RUN, busy=1 from the following cycle.
- Zero terminal: start with load_val==0.
  - Next cycle: state=DONE, done=1 for one cycle, expired=1, period=0, busy=0.
  - Applies in both modes; periodic mode does not loop on 0.
- RUN, on tick:
  - Up: period+1. Down: period-1.
  - End value is the terminal (up) or 0 (down). When the new value equals the end value, done=1 in the same cycle that period shows it, and expired=1.
- One-shot at end: next state DONE, period holds the end value, busy=0.
- Periodic at end:
  - State stays RUN. On the next tick period reloads to 0 (up) or terminal (down) instead of stepping.
  - Example: up with terminal 3 gives 0,1,2,3,0,1,2,3…; done pulses at each 3.
- Arithmetic: period never passes the end value, so no modular wrap occurs. Count width is exactly WIDTH.
- stop in RUN: next state PAUSE. period and prescaler freeze; done is not asserted.
- stop in IDLE, PAUSE or DONE: ignored.
- start in PAUSE: resume to RUN with no reload. period, prescaler and latched direction/mode/terminal are unchanged; expired is cleared.
- clear in any state: next state IDLE, period=0, done=0, expired=0, busy=0, prescaler=0.
- Input changes outside a start event: changes to direction, mode or load_val have no effect.
- done is never high for two consecutive cycles. With DIV=1 in periodic mode, successive pulses are at least 2 cycles apart.
- Reset asserted mid-count: all outputs return to reset values immediately. After release, the block stays IDLE until start.

Test Plan:
1. WIDTH=4, DIV=1, up, one-shot, load_val=5, pulse start → period 0,1,2,3,4,5 on consecutive cycles; done high for exactly one cycle, coincident with 5; then DONE, busy=0, expired=1, period holds 5.
2. DIV=3, down, periodic, load_val=2 → period steps every 3 cycles: 2,1,0,2,1,0; done pulses with each 0; busy stays 1.
3. Up, load_val=9, stop while period=4, hold 5 cycles, then start → period stays 4 during PAUSE, resumes at 5, done at 9, total run cycles = 9.
4. Start with load_val=0 → next cycle done=1, expired=1, state DONE, period=0. Repeat in periodic mode → identical single pulse, no looping.
5. Simultaneous clear+start+stop mid-run → IDLE, period=0, busy=0, expired=0. Start+stop without clear during RUN at period=3 → restart from 0.
6. Assert rst low asynchronously mid-count with period=6 and expired=1 → all outputs 0 before the next clock edge; no activity after release until start.
